// File: rtl/stream_mux_rr_if.sv
// Bundle of stream signals between N producers, the mux, and one shared consumer.
// A beat moves on a port at a rising clk edge only when valid and ready are both high there.
interface stream_mux_rr_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_ready;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-input stream mux with fixed-select or round-robin grant, feeding one
// full-throughput output register stage.
module stream_mux_rr #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_mux_rr_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  gnt_idx;
  logic              found;
  logic [WIDTH-1:0]  gnt_data;
  logic              accept;
  logic              xfer;

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  // Round-robin scans ptr, ptr+1, ... modulo NUM_CH; first valid channel wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    if (!bus.mode) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
          grant[i] = 1'b1;
          gnt_idx  = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (!found && bus.in_valid[i] &&
              (int'(ptr_q) + k == i || int'(ptr_q) + k == i + NUM_CH)) begin
            grant[i] = 1'b1;
            gnt_idx  = SEL_W'(i);
            found    = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == SEL_W'(i)) gnt_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  assign accept       = !out_valid_q || bus.out_ready;
  assign bus.in_ready = (rst_n && accept) ? grant : '0;
  assign xfer         = |bus.in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_ch_d    = gnt_idx;
      if (bus.mode) begin
        ptr_d = (gnt_idx == SEL_W'(NUM_CH - 1)) ? '0 : gnt_idx + SEL_W'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
endmodule
